anet_deser: RTL and testbench
=============================

# anet_deser

Serial-to-parallel loader that assembles WIDTH-bit words from a one-bit valid/ready stream. It drives the ANet bus of the downstream AND2/OR2 bus-analysis netlist (`top`). The parallel output changes only when a complete word is committed, so the downstream combinational bus never sees a partially shifted value. Malformed frames are counted and dropped.

## Interface
- WIDTH, 4: bits per word and width of `anet`; must be ≥ 2.
- LSB_FIRST, 1: 1 puts the first received bit in `anet[0]`; 0 puts it in `anet[WIDTH-1]`.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sin_valid  in  1  serial bit valid.
- sin_data  in  1  serial bit.
- sin_last  in  1  marks the final bit of a frame; qualified by sin_valid & sin_ready.
- sin_ready  out  1  loader accepts a bit this cycle.
- anet  out  WIDTH  committed parallel word, drives the downstream ANet bus.
- anet_valid  out  1  `anet` holds a new word not yet acknowledged.
- anet_ack  in  1  consumer accepts the word.
- frame_err  out  1  one-cycle pulse on a dropped frame.
- err_cnt  out  ERR_W  saturating count of dropped frames.

## Operation
- State machine with two states:
  - SHIFT: collecting bits.
  - HOLD: word committed, waiting for ack.
- Reset values:
  - State is SHIFT and bit count is 0.
  - Shift register, `anet`, `anet_valid`, `frame_err` and `err_cnt` are all 0.
- `sin_ready` = (state==SHIFT) & !rst. It is decoded from registered state only.
- Accept = sin_valid & sin_ready at a rising edge. An accepted bit is written into the shadow shift register at position cnt (LSB_FIRST=1) or WIDTH-1-cnt (LSB_FIRST=0). The count then increments.
- Commit happens when the accepted bit is the WIDTH-th (cnt==WIDTH-1):
  - `anet` ← shadow word with the incoming bit merged.
  - `anet_valid` ← 1, state ← HOLD, cnt ← 0.
  - `sin_last` on this bit is optional and has no further effect.
- Frame error is raised when `sin_last` is accepted with cnt < WIDTH-1:
  - The partial word is discarded and cnt ← 0.
  - `anet` and `anet_valid` are unchanged and state stays SHIFT.
  - `frame_err` pulses 1 for exactly one cycle.
  - `err_cnt` increments, saturating at 2^ERR_W-1.
- HOLD:
  - `sin_ready` = 0 and no bits are consumed.
  - When `anet_ack` is high at an edge: `anet_valid` ← 0 and state ← SHIFT.
  - `anet` keeps its value until the next commit.
- `anet_ack` while `anet_valid`=0 is ignored.
- Reset mid-frame or mid-HOLD:
  - All state returns to reset values and any partial bits are lost.
  - `anet` clears to 0, so downstream sees an all-zero bus.
- The shadow register is never visible on `anet`.

## Timing
- All outputs are registered except `sin_ready`, which is a decode of the registered state.
- Commit latency: `anet` and `anet_valid` are valid in the cycle after the edge that accepts the WIDTH-th bit.
- Ack to ready: `sin_ready` = 1 in the cycle after the edge that samples `anet_ack`.
- Throughput, back-to-back with `anet_ack` tied high: one word per WIDTH+1 cycles.
- `frame_err` is high for the single cycle after the offending edge.
- Error counter:
  - `err_cnt` updates on that same edge.
  - It holds at the maximum value after saturating.
  - Its saturation does not block frame dropping.
- With `rst` high, `sin_ready` = 0 combinationally and all registers load their reset values at the edge.

## Test plan
- **LSB-first word:** WIDTH=4, LSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, last bit with `sin_last`=1 → `anet`=4'b1101 and `anet_valid`=1 in the cycle after the 4th accept. Downstream Ynet = (1&0)|(1&1) = 1.
- **MSB-first word:** LSB_FIRST=0, bits 1,0,0,0 → `anet`=4'b1000.
- **Backpressure:** `anet_ack` held 0 for 5 cycles with `sin_valid`=1 → `sin_ready`=0 throughout, `anet` stable, no bits consumed. After `anet_ack`=1 for one cycle, `sin_ready`=1 on the following cycle and the next 4 bits form the next word.
- **Frame error:** bits 1,1 with `sin_last` on the 2nd bit → `frame_err` one-cycle pulse, `err_cnt`=1, `anet` and `anet_valid` unchanged. The next bits 0,1,0,1 commit as `anet`=4'b1010.
- **Reset mid-word:** 2 bits accepted, then `rst` for 1 cycle → `anet`=0, `anet_valid`=0. Then bits 0,0,0,1 → `anet`=4'b1000, confirming no stale bits.
- **Counter saturation:** ERR_W=8 and 260 short frames → `err_cnt` stays 255, and `frame_err` still pulses on every dropped frame.

Source files
------------

// File: rtl/anet_deser.sv
// Serial-to-parallel loader for the ANet bus: collects WIDTH bits from a valid/ready
// stream and publishes the complete word on anet only once it is fully assembled.
module anet_deser #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_last,
    output logic             sin_ready,
    output logic [WIDTH-1:0] anet,
    output logic             anet_valid,
    input  logic             anet_ack,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic {
        SHIFT = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] merged;
    logic [CNT_W-1:0] pos;
    logic             accept;

    assign sin_ready = (state == SHIFT) && !rst;
    assign accept    = sin_valid && sin_ready;

    // Shadow word with the incoming bit dropped into its slot; only a full word reaches anet.
    always_comb begin
        pos    = (LSB_FIRST != 0) ? cnt : (LAST_POS - cnt);
        merged = shadow;
        merged[pos] = sin_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SHIFT;
            cnt        <= '0;
            shadow     <= '0;
            anet       <= '0;
            anet_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (cnt == LAST_POS) begin
                            anet       <= merged;
                            anet_valid <= 1'b1;
                            state      <= HOLD;
                            cnt        <= '0;
                            shadow     <= '0;
                        end else if (sin_last) begin
                            // Short frame: discard the partial word, count it, stay collecting.
                            cnt       <= '0;
                            shadow    <= '0;
                            frame_err <= 1'b1;
                            if (err_cnt != ERR_MAX)
                                err_cnt <= err_cnt + 1'b1;
                        end else begin
                            shadow <= merged;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (anet_ack) begin
                        anet_valid <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_anet_deser.sv
// Randomised and directed bench for anet_deser; both bit orders run side by side
// against a queue-based model of the framing rules.
module tb_anet_deser;

    localparam int WIDTH = 4;
    localparam int ERR_W = 8;

    logic clk;
    logic rst;
    logic sin_valid, sin_data, sin_last, anet_ack;

    logic             ready_l, ready_m;
    logic [WIDTH-1:0] anet_l, anet_m;
    logic             avalid_l, avalid_m;
    logic             ferr_l, ferr_m;
    logic [ERR_W-1:0] errc_l, errc_m;

    anet_deser #(.WIDTH(WIDTH), .LSB_FIRST(1), .ERR_W(ERR_W)) dut_lsb (
        .clk(clk), .rst(rst),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_last(sin_last),
        .sin_ready(ready_l), .anet(anet_l), .anet_valid(avalid_l),
        .anet_ack(anet_ack), .frame_err(ferr_l), .err_cnt(errc_l)
    );

    anet_deser #(.WIDTH(WIDTH), .LSB_FIRST(0), .ERR_W(ERR_W)) dut_msb (
        .clk(clk), .rst(rst),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_last(sin_last),
        .sin_ready(ready_m), .anet(anet_m), .anet_valid(avalid_m),
        .anet_ack(anet_ack), .frame_err(ferr_m), .err_cnt(errc_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: received bits held in a queue, word formed only when WIDTH are in.
    bit      bits[$];
    bit [WIDTH-1:0] m_anet_l, m_anet_m;
    bit      m_valid;
    bit      m_ferr;
    int      m_errc;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        bits.delete();
        m_anet_l = '0;
        m_anet_m = '0;
        m_valid  = 1'b0;
        m_ferr   = 1'b0;
        m_errc   = 0;
    endtask

    task automatic modelEdge(input bit v, input bit d, input bit l, input bit a, input bit r);
        if (r) begin
            modelReset();
        end else begin
            m_ferr = 1'b0;
            if (!m_valid) begin
                if (v) begin
                    bits.push_back(d);
                    if (bits.size() == WIDTH) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            m_anet_l[i]           = bits[i];
                            m_anet_m[WIDTH-1-i]   = bits[i];
                        end
                        m_valid = 1'b1;
                        bits.delete();
                    end else if (l) begin
                        bits.delete();
                        m_ferr = 1'b1;
                        if (m_errc < (1 << ERR_W) - 1)
                            m_errc++;
                    end
                end
            end else if (a) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check the ready decode, clock, then check registered outputs.
    task automatic applyStimulus(input bit v, input bit d, input bit l, input bit a, input bit r);
        sin_valid = v;
        sin_data  = d;
        sin_last  = l;
        anet_ack  = a;
        rst       = r;
        #1;
        checkOutput("ready_lsb", 32'(ready_l), 32'(!m_valid && !r));
        checkOutput("ready_msb", 32'(ready_m), 32'(!m_valid && !r));
        @(posedge clk);
        modelEdge(v, d, l, a, r);
        #1;
        checkOutput("anet_lsb",   32'(anet_l),   32'(m_anet_l));
        checkOutput("anet_msb",   32'(anet_m),   32'(m_anet_m));
        checkOutput("valid_lsb",  32'(avalid_l), 32'(m_valid));
        checkOutput("valid_msb",  32'(avalid_m), 32'(m_valid));
        checkOutput("ferr_lsb",   32'(ferr_l),   32'(m_ferr));
        checkOutput("ferr_msb",   32'(ferr_m),   32'(m_ferr));
        checkOutput("errcnt_lsb", 32'(errc_l),   32'(m_errc));
        checkOutput("errcnt_msb", 32'(errc_m),   32'(m_errc));
    endtask

    task automatic sendWord(input bit [WIDTH-1:0] w, input bit with_last);
        for (int i = 0; i < WIDTH; i++)
            applyStimulus(1'b1, w[i], with_last && (i == WIDTH - 1), 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_anet", 32'(anet_l), 32'h0);

        // Bits in arrival order 1,0,1,1 (index 0 first).
        sendWord(4'b1101, 1'b1);
        checkOutput("lsb_word", 32'(anet_l), 32'hD);
        checkOutput("msb_word", 32'(anet_m), 32'hB);
        checkOutput("ynet", 32'((anet_l[0] & anet_l[1]) | (anet_l[2] & anet_l[3])), 32'h1);

        // Backpressure: held word, stream offered but not consumed.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stable", 32'(anet_l), 32'hD);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        sendWord(4'b0001, 1'b0);
        checkOutput("msb_1000", 32'(anet_m), 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Short frame then a full word.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ferr_pulse", 32'(ferr_l), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ferr_one_cycle", 32'(ferr_l), 32'h0);
        sendWord(4'b1010, 1'b0);
        checkOutput("after_err_word", 32'(anet_l), 32'hA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word discards partial bits.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(4'b1000, 1'b0);
        checkOutput("post_reset_word", 32'(anet_l), 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation: 260 one-bit frames.
        for (int i = 0; i < 260; i++)
            applyStimulus(1'b1, 1'(i), 1'b1, 1'b0, 1'b0);
        checkOutput("err_saturated", 32'(errc_l), 32'd255);
        checkOutput("ferr_at_sat", 32'(ferr_l), 32'h1);

        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
